osd_spi_sched: RTL and testbench



---
 rtl/osd_spi_sched.sv | 148 ++++++++++++++
 tb/tb_osd_spi_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/osd_spi_sched.sv
// rtl/osd_spi_sched.sv - round-robin scheduler serialising two requesters onto the OSD SPI pins
// Each grant emits SS-framed command byte plus 0..256 payload bytes, MSB first, SCK idle low.
module osd_spi_sched #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] cmd0,
  input  logic [7:0] cmd1,
  input  logic [8:0] len0,
  input  logic [8:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [7:0] rd_addr,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_ss,
  output logic       spi_di
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] DONE_AT   = 9'(2 * CLK_DIV - 2);

  state_t     state;
  logic [8:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic [8:0] rem;
  logic [7:0] cmd_q;
  logic       sel;
  logic       lp;

  logic       pick;
  logic [8:0] len_pick;
  logic [8:0] len_clip;
  logic [7:0] data_sel;

  // On a tie the requester that was not served last wins.
  assign pick     = (req == 2'b11) ? ~lp : req[1];
  assign len_pick = pick ? len1 : len0;
  assign len_clip = (len_pick > 9'd256) ? 9'd256 : len_pick;
  assign data_sel = sel ? data1 : data0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      rem     <= '0;
      cmd_q   <= '0;
      sel     <= 1'b0;
      lp      <= 1'b1;
      rd_addr <= '0;
      gnt     <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      spi_sck <= 1'b0;
      spi_ss  <= 1'b1;
      spi_di  <= 1'b0;
    end else begin
      done <= 2'b00;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state   <= SETUP;
            cnt     <= '0;
            sel     <= pick;
            lp      <= pick;
            gnt     <= pick ? 2'b10 : 2'b01;
            cmd_q   <= pick ? cmd1 : cmd0;
            rem     <= len_clip;
            rd_addr <= '0;
            busy    <= 1'b1;
            spi_ss  <= 1'b0;
            spi_sck <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= cmd_q;
            spi_di  <= cmd_q[7];
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        SHIFT: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 9'd1;
          end else begin
            cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              // Falling SCK: present the next bit, or load the next byte after bit 0.
              spi_sck <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= {sh[6:0], 1'b0};
                spi_di  <= sh[6];
              end else if (rem != 9'd0) begin
                bit_cnt <= '0;
                sh      <= data_sel;
                spi_di  <= data_sel[7];
                rd_addr <= rd_addr + 8'd1;
                rem     <= rem - 9'd1;
              end else begin
                state  <= HOLD;
                spi_di <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (cnt == HALF_LAST) begin
            state  <= GAP;
            cnt    <= '0;
            spi_ss <= 1'b1;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        GAP: begin
          if (cnt == DONE_AT) done <= gnt;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= 2'b00;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_spi_sched.sv
// tb/tb_osd_spi_sched.sv - directed and randomized checks of osd_spi_sched against a frame-level OSD model
module tb_osd_spi_sched;

  localparam int CD = 2;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] req     = 2'b00;
  logic [7:0] cmd0    = 8'h00;
  logic [7:0] cmd1    = 8'h00;
  logic [8:0] len0    = 9'd0;
  logic [8:0] len1    = 9'd0;
  logic [7:0] data0   = 8'h00;
  logic [7:0] data1   = 8'h00;
  logic [7:0] key0    = 8'h00;
  logic [7:0] rd_addr;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       spi_sck;
  logic       spi_ss;
  logic       spi_di;

  int checks = 0;
  int errors = 0;
  int lp_m   = 1;

  osd_spi_sched #(.CLK_DIV(CD)) dut (
    .clk_sys(clk_sys), .reset(reset), .req(req),
    .cmd0(cmd0), .cmd1(cmd1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .rd_addr(rd_addr),
    .gnt(gnt), .done(done), .busy(busy),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_di(spi_di)
  );

  always #5 clk_sys = ~clk_sys;

  // Requester payload memories with one cycle of read latency.
  always @(posedge clk_sys) begin
    data0 <= rd_addr ^ key0;
    data1 <= rd_addr ^ 8'h5A;
  end

  // OSD side: sample DI on SCK rise, frame bytes by SS.
  logic [7:0] cur_frame[$];
  logic [7:0] last_frame[$];
  logic [7:0] sh_m = 8'h00;
  int         bitn = 0;
  int         rises = 0;

  always @(negedge spi_ss) begin
    cur_frame.delete();
    bitn = 0;
  end

  always @(posedge spi_sck) begin
    rises++;
    sh_m = {sh_m[6:0], spi_di};
    bitn++;
    if (bitn == 8) begin
      cur_frame.push_back(sh_m);
      bitn = 0;
    end
  end

  always @(posedge spi_ss) last_frame = cur_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] arb(input logic [1:0] r);
    if (r == 2'b11) return (lp_m == 1) ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic note_grant(input logic [1:0] g);
    lp_m = g[1] ? 1 : 0;
  endtask

  // Observe one whole transaction and compare it with what the OSD should have received.
  task automatic txn(input logic [1:0] exp_g, input logic [7:0] exp_cmd, input int len_in,
                     input int drop_bytes, input logic [1:0] clr, input string tag);
    int L, cyc, dg, dother, r0, waitc, bad;
    logic [7:0] key, eb;
    L = (len_in > 256) ? 256 : len_in;
    waitc = 0;
    while (gnt === 2'b00 && waitc < 20) begin
      @(negedge clk_sys);
      waitc++;
    end
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    note_grant(exp_g);
    r0 = rises; cyc = 0; dg = 0; dother = 0;
    while (gnt !== 2'b00 && cyc < 20000) begin
      cyc++;
      if ((done & exp_g) != 2'b00) dg++;
      if ((done & ~exp_g) != 2'b00) dother++;
      if (drop_bytes > 0 && cur_frame.size() >= drop_bytes) req = req & ~exp_g;
      if ((done & exp_g) != 2'b00) req = req & ~clr;
      @(negedge clk_sys);
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(CD * (1 + 16 * (1 + L) + 1 + 2)));
    check({tag, "_done"}, 32'(dg), 32'd1);
    check({tag, "_done_other"}, 32'(dother), 32'd0);
    check({tag, "_rises"}, 32'(rises - r0), 32'(8 * (1 + L)));
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'(L % 256));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    key = exp_g[1] ? 8'h5A : key0;
    bad = 0;
    if (last_frame.size() == 1 + L) begin
      for (int k = 0; k <= L; k++) begin
        eb = (k == 0) ? exp_cmd : (8'(k - 1) ^ key);
        if (last_frame[k] !== eb) bad++;
      end
    end
    check({tag, "_frame_len"}, 32'(last_frame.size()), 32'(1 + L));
    check({tag, "_frame_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    req = 2'b00;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    lp_m = 1;
  endtask

  initial begin
    int r0, waitc, dseen, n;
    logic [1:0] p, g;

    // Reset state and quiet idle
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    check("rst_ss", 32'(spi_ss), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_di", 32'(spi_di), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    r0 = rises;
    repeat (100) @(negedge clk_sys);
    check("idle_rises", 32'(rises - r0), 32'd0);
    check("idle_ss", 32'(spi_ss), 32'd1);

    // Enable command, no payload
    cmd0 = 8'h41; len0 = 9'd0; req = 2'b01;
    txn(2'b01, 8'h41, 0, 0, 2'b01, "enable");

    // Full line write from requester 1
    cmd1 = 8'h23; len1 = 9'd256; req = 2'b10;
    txn(2'b10, 8'h23, 256, 0, 2'b10, "line");
    check("line_last_byte", 32'(last_frame[256]), 32'h000000A5);

    // Tie right after reset: requester 0 first, then 1
    do_reset();
    cmd0 = 8'($urandom); cmd1 = 8'($urandom);
    len0 = 9'($urandom_range(0, 3)); len1 = 9'($urandom_range(0, 3));
    key0 = 8'($urandom);
    req = 2'b11;
    g = arb(req);
    txn(g, cmd0, int'(len0), 0, 2'b01, "tie_first");
    g = arb(req);
    txn(g, cmd1, int'(len1), 0, 2'b10, "tie_second");

    // Held tie alternates over four transactions
    do_reset();
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      g = arb(2'b11);
      txn(g, g[1] ? cmd1 : cmd0, g[1] ? int'(len1) : int'(len0), 0,
          (t == 3) ? 2'b11 : 2'b00, $sformatf("hold%0d", t));
    end

    // Oversized length clips to 256, and req dropped mid-transaction
    cmd0 = 8'h24; len0 = 9'd300; key0 = 8'($urandom); req = 2'b01;
    txn(2'b01, 8'h24, 300, 0, 2'b01, "clip");
    cmd0 = 8'h25; len0 = 9'd6; req = 2'b01;
    txn(2'b01, 8'h25, 6, 3, 2'b01, "drop");

    // Randomized request patterns against the arbitration model
    for (int t = 0; t < 6; t++) begin
      cmd0 = 8'($urandom); cmd1 = 8'($urandom);
      len0 = 9'($urandom_range(0, 5)); len1 = 9'($urandom_range(0, 5));
      key0 = 8'($urandom);
      p = 2'($urandom_range(1, 3));
      req = p;
      g = arb(p);
      txn(g, g[1] ? cmd1 : cmd0, g[1] ? int'(len1) : int'(len0), 0, 2'b11,
          $sformatf("rnd%0d", t));
    end

    // Reset during payload byte 5
    cmd0 = 8'h22; len0 = 9'd10; req = 2'b01;
    waitc = 0;
    while (gnt === 2'b00 && waitc < 20) begin
      @(negedge clk_sys);
      waitc++;
    end
    check("abort_gnt", 32'(gnt), 32'd1);
    waitc = 0;
    while (cur_frame.size() < 5 && waitc < 2000) begin
      @(negedge clk_sys);
      waitc++;
    end
    check("abort_reached", 32'(cur_frame.size() >= 5), 32'd1);
    reset = 1'b1;
    req = 2'b00;
    @(negedge clk_sys);
    check("abort_ss", 32'(spi_ss), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_gnt_clr", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    lp_m = 1;
    dseen = 0;
    n = 0;
    while (n < 30) begin
      if (done !== 2'b00) dseen++;
      @(negedge clk_sys);
      n++;
    end
    check("abort_no_done", 32'(dseen), 32'd0);
    key0 = 8'($urandom);
    cmd0 = 8'h40; len0 = 9'd4; req = 2'b01;
    txn(2'b01, 8'h40, 4, 0, 2'b01, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
